// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the ALU sequencing controller.
package alu_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StMulStep,
    StDone
  } state_e;

  localparam logic [2:0]  OP_ADD = 3'b000;
  localparam int unsigned W_DEF  = 4;

endpackage

// File: rtl/mul_shift_reg.sv
// Shift-add multiplier accumulator {hi, lo}; the add itself happens on the external adder.
module mul_shift_reg #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         step,
  input  logic [W-1:0] load_lo,
  input  logic [W-1:0] sum,
  input  logic         cout,
  output logic [W-1:0] hi_next,
  output logic [W-1:0] lo_next
);

  logic [W-1:0] hi_q, lo_q;

  // lo[0] selects whether this step keeps the adder result (hi + a) or just shifts.
  always_comb begin
    hi_next = {1'b0, hi_q[W-1:1]};
    lo_next = {hi_q[0], lo_q[W-1:1]};
    if (lo_q[0]) begin
      hi_next = {cout, sum[W-1:1]};
      lo_next = {sum[0], lo_q[W-1:1]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (load) begin
      hi_q <= '0;
      lo_q <= load_lo;
    end else if (step) begin
      hi_q <= hi_next;
      lo_q <= lo_next;
    end
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Command sequencer for the 4-bit ALU datapath: single-cycle ops and shift-add multiply.
module alu_seq_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned W = W_DEF
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [W-1:0]   cmd_a,
  input  logic [W-1:0]   cmd_b,
  input  logic [2:0]     cmd_op,
  input  logic           cmd_mul,
  output logic [W-1:0]   dp_a,
  output logic [W-1:0]   dp_b,
  output logic [2:0]     dp_op,
  input  logic [W-1:0]   dp_sum,
  input  logic           dp_cout,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [2*W-1:0] res_data,
  output logic           res_cout,
  output logic           res_zero,
  output logic           busy
);

  localparam int unsigned SW = $clog2(W);
  localparam logic [SW-1:0] LastStep = SW'(W - 1);

  state_e         state_q, state_d;
  logic [SW-1:0]  step_q;
  logic [W-1:0]   dp_a_q, dp_b_q;
  logic [2:0]     dp_op_q;
  logic [2*W-1:0] res_data_q;
  logic           res_cout_q;
  logic           accept, mul_load, mul_step, last_step;
  logic [W-1:0]   hi_next, lo_next;

  assign accept    = cmd_valid && (state_q == StIdle);
  assign mul_load  = accept && cmd_mul;
  assign mul_step  = (state_q == StMulStep);
  assign last_step = mul_step && (step_q == LastStep);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (cmd_valid) state_d = cmd_mul ? StMulStep : StExec;
      StExec:    state_d = StDone;
      StMulStep: if (step_q == LastStep) state_d = StDone;
      StDone:    if (res_ready) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      step_q     <= '0;
      dp_a_q     <= '0;
      dp_b_q     <= '0;
      dp_op_q    <= '0;
      res_data_q <= '0;
      res_cout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      // Wraps back to zero on the final step, ready for the next multiply.
      if (mul_step) step_q <= step_q + 1'b1;
      if (accept) begin
        if (cmd_mul) begin
          dp_a_q  <= '0;
          dp_b_q  <= cmd_a;
          dp_op_q <= OP_ADD;
        end else begin
          dp_a_q  <= cmd_a;
          dp_b_q  <= cmd_b;
          dp_op_q <= cmd_op;
        end
      end else if (mul_step) begin
        dp_a_q <= hi_next;
      end
      if (state_q == StExec) begin
        res_data_q <= {{W{1'b0}}, dp_sum};
        res_cout_q <= dp_cout;
      end else if (last_step) begin
        res_data_q <= {hi_next, lo_next};
        res_cout_q <= 1'b0;
      end
    end
  end

  mul_shift_reg #(
    .W(W)
  ) u_mul_shift_reg (
    .clk     (clk),
    .reset   (reset),
    .load    (mul_load),
    .step    (mul_step),
    .load_lo (cmd_b),
    .sum     (dp_sum),
    .cout    (dp_cout),
    .hi_next (hi_next),
    .lo_next (lo_next)
  );

  assign cmd_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign res_valid = (state_q == StDone);
  assign res_data  = res_data_q;
  assign res_cout  = res_cout_q;
  assign res_zero  = (res_data_q == '0);
  assign dp_a      = dp_a_q;
  assign dp_b      = dp_b_q;
  assign dp_op     = dp_op_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed self-checking bench for alu_seq_ctrl with a behavioural preprocessor/adder model.
module tb_alu_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid, cmd_ready, cmd_mul;
  logic [3:0] cmd_a, cmd_b;
  logic [2:0] cmd_op;
  logic [3:0] dp_a, dp_b, dp_sum;
  logic [2:0] dp_op;
  logic       dp_cout;
  logic       res_valid, res_ready, res_cout, res_zero, busy;
  logic [7:0] res_data;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  alu_seq_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_op    (cmd_op),
    .cmd_mul   (cmd_mul),
    .dp_a      (dp_a),
    .dp_b      (dp_b),
    .dp_op     (dp_op),
    .dp_sum    (dp_sum),
    .dp_cout   (dp_cout),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_cout  (res_cout),
    .res_zero  (res_zero),
    .busy      (busy)
  );

  // Preprocessor: op[1] zeroes A, op[0] complements B and injects carry-in.
  logic [3:0] a_eff, b_eff;
  always_comb begin
    a_eff = dp_op[1] ? 4'd0 : dp_a;
    b_eff = dp_op[0] ? ~dp_b : dp_b;
    {dp_cout, dp_sum} = {1'b0, a_eff} + {1'b0, b_eff} + 5'(dp_op[0]);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a command for one edge (the block is idle, so it is accepted at that edge).
  task automatic issue(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op,
                       input logic mul);
    cmd_valid = 1'b1;
    cmd_a     = a;
    cmd_b     = b;
    cmd_op    = op;
    cmd_mul   = mul;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic consume();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("released_valid", 32'(res_valid), 32'd0);
    chk("released_ready", 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_a     = '0;
    cmd_b     = '0;
    cmd_op    = '0;
    cmd_mul   = 1'b0;
    res_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    #2;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_data",  32'(res_data),  32'd0);
    chk("rst_res_cout",  32'(res_cout),  32'd0);
    chk("rst_res_zero",  32'(res_zero),  32'd1);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_dp",        {20'd0, dp_a, dp_b, 1'b0, dp_op}, 32'd0);

    // 5 + 3: one-cycle latency.
    issue(4'd5, 4'd3, 3'b000, 1'b0);
    chk("add1_exec_valid", 32'(res_valid), 32'd0);
    chk("add1_exec_busy",  32'(busy),      32'd1);
    chk("add1_dp",         {20'd0, dp_a, dp_b, 1'b0, dp_op}, {20'd0, 4'd5, 4'd3, 4'd0});
    tick();
    chk("add1_valid", 32'(res_valid), 32'd1);
    chk("add1_data",  32'(res_data),  32'h08);
    chk("add1_cout",  32'(res_cout),  32'd0);
    chk("add1_zero",  32'(res_zero),  32'd0);
    consume();

    // 9 + 8 overflows the 4-bit sum.
    issue(4'd9, 4'd8, 3'b000, 1'b0);
    tick();
    chk("add2_valid", 32'(res_valid), 32'd1);
    chk("add2_data",  32'(res_data),  32'h01);
    chk("add2_cout",  32'(res_cout),  32'd1);
    chk("add2_zero",  32'(res_zero),  32'd0);
    consume();

    // Non-add opcode reaches the datapath unchanged: 5 - 3 = 2 with carry 1.
    issue(4'd5, 4'd3, 3'b001, 1'b0);
    chk("sub_dp_op", 32'(dp_op), 32'd1);
    tick();
    chk("sub_data", 32'(res_data), 32'h02);
    chk("sub_cout", 32'(res_cout), 32'd1);
    consume();

    // 7 * 6: four steps with OP_ADD on the datapath.
    issue(4'd7, 4'd6, 3'b111, 1'b1);
    for (int s = 0; s < 4; s++) begin
      chk($sformatf("mul76_step%0d_op", s), 32'(dp_op), 32'd0);
      chk($sformatf("mul76_step%0d_b", s), 32'(dp_b), 32'd7);
      chk($sformatf("mul76_step%0d_valid", s), 32'(res_valid), 32'd0);
      tick();
    end
    chk("mul76_valid", 32'(res_valid), 32'd1);
    chk("mul76_data",  32'(res_data),  32'h2A);
    chk("mul76_cout",  32'(res_cout),  32'd0);
    consume();

    // 15 * 15, then hold the result with a new command waiting.
    issue(4'd15, 4'd15, 3'b000, 1'b1);
    repeat (4) tick();
    chk("mul_ff_valid", 32'(res_valid), 32'd1);
    chk("mul_ff_data",  32'(res_data),  32'hE1);
    cmd_valid = 1'b1;
    cmd_a     = 4'd1;
    cmd_b     = 4'd1;
    cmd_op    = 3'b000;
    cmd_mul   = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk($sformatf("hold%0d_data", c), 32'(res_data), 32'hE1);
      chk($sformatf("hold%0d_valid", c), 32'(res_valid), 32'd1);
      chk($sformatf("hold%0d_ready", c), 32'(cmd_ready), 32'd0);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("hold_release_ready", 32'(cmd_ready), 32'd1);
    chk("hold_release_valid", 32'(res_valid), 32'd0);
    tick();
    cmd_valid = 1'b0;
    chk("hold_new_taken", 32'(cmd_ready), 32'd0);
    tick();
    chk("hold_new_data", 32'(res_data), 32'h02);
    consume();

    // 0 * 11 yields zero.
    issue(4'd0, 4'd11, 3'b000, 1'b1);
    repeat (4) tick();
    chk("mul_zero_valid", 32'(res_valid), 32'd1);
    chk("mul_zero_data",  32'(res_data),  32'h00);
    chk("mul_zero_flag",  32'(res_zero),  32'd1);
    consume();

    // Reset while the multiply sits at step 2.
    issue(4'd7, 4'd6, 3'b000, 1'b1);
    tick();
    tick();
    chk("abort_pre_busy", 32'(busy), 32'd1);
    chk("abort_pre_dp_b", 32'(dp_b), 32'd7);
    reset = 1'b1;
    #2;
    chk("abort_ready", 32'(cmd_ready), 32'd1);
    chk("abort_valid", 32'(res_valid), 32'd0);
    chk("abort_busy",  32'(busy),      32'd0);
    chk("abort_data",  32'(res_data),  32'd0);
    chk("abort_dp",    {20'd0, dp_a, dp_b, 1'b0, dp_op}, 32'd0);
    #2;
    reset = 1'b0;
    issue(4'd2, 4'd2, 3'b000, 1'b0);
    tick();
    chk("post_abort_valid", 32'(res_valid), 32'd1);
    chk("post_abort_data",  32'(res_data),  32'h04);
    consume();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

Sequencing controller for the 4-bit ALU datapath (operand preprocessor + 4-bit adder). It accepts one command at a time over a valid/ready handshake and drives the datapath's A, B and Op inputs from registered operands. It captures the adder sum and carry, and holds the result until it is consumed. Multiply commands run as a 4-step shift-add sequence on the same adder, so no extra arithmetic hardware is needed.

## Interface
- W, 4, datapath operand width; the whole block is verified only at 4.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command (high only in IDLE).
- cmd_a  in  W  operand A.
- cmd_b  in  W  operand B.
- cmd_op  in  3  datapath opcode for single-cycle commands.
- cmd_mul  in  1  1 = unsigned W×W multiply (cmd_op ignored).
- dp_a  out  W  to preprocessor A.
- dp_b  out  W  to preprocessor B.
- dp_op  out  3  to preprocessor Op.
- dp_sum  in  W  adder sum (combinational from dp_a/dp_b/dp_op).
- dp_cout  in  1  adder carry-out.
- res_valid  out  1  result available.
- res_ready  in  1  consumer takes result.
- res_data  out  2W  result; single ops zero-extend dp_sum.
- res_cout  out  1  carry of single op; 0 for multiply.
- res_zero  out  1  res_data == 0.
- busy  out  1  state != IDLE.

## Operation
- FSM states:
  - IDLE: cmd_ready=1. On cmd_valid, latch a_r, b_r, op_r and mul_r. Go to EXEC if cmd_mul=0, else MUL_STEP with hi=0, lo=b_r, step=0.
  - EXEC: dp_a=a_r, dp_b=b_r, dp_op=op_r. At the clock edge, capture res_data={0,dp_sum}, res_cout=dp_cout, then go to DONE.
  - MUL_STEP: dp_a=hi, dp_b=a_r, dp_op=OP_ADD (3'b000, preprocessor passes A and B, no complement).
    - Each edge: if lo[0], {c,hi,lo} ← {dp_cout, dp_sum, lo} >> 1; else {c,hi,lo} ← {0, hi, lo} >> 1. Then step++.
    - After step W-1, capture res_data={hi',lo'} and go to DONE.
  - DONE: res_valid=1 and outputs are stable. On res_ready, go to IDLE.
- dp_* outputs are driven from registers only. In IDLE/DONE they hold their last values; after reset they are 0.
- res_zero is derived from the registered res_data.

## Timing
- Reset (async): state=IDLE, all registers 0. Outputs: cmd_ready=1, res_valid=0, res_data=0, res_cout=0, res_zero=1, busy=0, dp_a=dp_b=dp_op=0.
- Acceptance occurs at edge E0 where cmd_valid&cmd_ready.
  - Single op: res_valid rises after E1 (1-cycle latency).
  - Multiply: res_valid rises after E(W), i.e. E4 for W=4.
- Result is held while res_valid & !res_ready, for any number of cycles.
- Release at an edge with res_valid&res_ready. cmd_ready returns high the following cycle; there is no same-cycle bypass and no back-to-back pipelining.
- cmd_valid outside IDLE is ignored; commands are not queued.
- res_ready outside DONE is ignored.
- Reset asserted mid-sequence aborts immediately to the reset values; no partial result is presented.
- Step counter is log2(W) bits and wraps only via the state exit.

## Structure
- Package alu_ctrl_pkg contains:
  - state enum {IDLE, EXEC, MUL_STEP, DONE};
  - localparam OP_ADD = 3'b000;
  - localparam W_DEF = 4.
- One sub-module is natural: mul_shift_reg, holding {hi, lo} with load/step controls and the conditional-add select. The FSM and handshakes live in the top.
- Preprocessor and adder stay outside. The bench connects them, or an equivalent behavioural model, between dp_* and dp_sum/dp_cout.

## Test plan
- Reset, then cmd A=5, B=3, op=000, mul=0 -> res_valid one cycle after accept; res_data=0x08, res_cout=0, res_zero=0.
- A=9, B=8, op=000 -> res_data=0x01, res_cout=1, res_zero=0.
- Multiply A=7, B=6 -> res_valid 4 cycles after accept; res_data=0x2A, res_cout=0. Check dp_op=000 during all 4 steps.
- Multiply A=15, B=15 -> res_data=0xE1. Multiply A=0, B=11 -> res_data=0x00, res_zero=1.
- Hold res_ready=0 for 5 cycles with cmd_valid=1 and a new command present -> result stable, cmd_ready=0, new command not taken. Release -> cmd_ready=1 the next cycle, new command accepted.
- Assert reset during MUL_STEP at step 2 -> state IDLE, res_valid=0, dp_*=0. A following ADD 2+2 returns 0x04.
